timer_apb_ctrl: RTL

APB4 slave front-end that sequences every bus access into the timer register file. It latches the APB setup phase and inserts a parameterised number of wait states. It then issues exactly one single-cycle `r_en`/`w_en` strobe and returns `prdata`/`pslverr` with `pready`. It also provides a coherent 64-bit counter read: a TDR0 read snapshots the upper counter word, and the next TDR1 read returns that snapshot. It sits between the APB interconnect and the register file.

---
 rtl/timer_pkg.sv | 20 ++
 rtl/timer_apb_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// Shared timer definitions: register map and APB control FSM states.
package timer_pkg;

    localparam logic [11:0] ADDR_TCR   = 12'h000;
    localparam logic [11:0] ADDR_TDR0  = 12'h004;
    localparam logic [11:0] ADDR_TDR1  = 12'h008;
    localparam logic [11:0] ADDR_TCMP0 = 12'h00C;
    localparam logic [11:0] ADDR_TCMP1 = 12'h010;
    localparam logic [11:0] ADDR_TIER  = 12'h014;
    localparam logic [11:0] ADDR_TISR  = 12'h018;
    localparam logic [11:0] ADDR_THCSR = 12'h01C;
    localparam logic [11:0] ADDR_LAST  = ADDR_THCSR;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/timer_apb_ctrl.sv
// APB4 slave front-end sequencing each access into one r_en/w_en strobe, with coherent 64-bit counter read.
// Latency: pready WAIT_STATES+1 cycles after the setup phase; one transfer per 2+WAIT_STATES cycles.
// Backpressure: pready held low through wait states; master dropping psel/penable aborts without a strobe.
module timer_apb_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        r_en,
    output logic        w_en,
    output logic [11:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  byte_en,
    input  logic [31:0] rdata,
    input  logic        error,
    input  logic [63:0] counter
);

    localparam logic [1:0] WS_INIT = 2'(WAIT_STATES);

    ctrl_state_t state_q, state_d;
    logic [1:0]  wait_q;
    logic        wr_q;
    logic [31:0] hi_shadow;
    logic        shadow_valid;

    logic setup, access, issue, dec_err, tdr1_hit;
    logic unused_counter_lo;

    assign unused_counter_lo = ^counter[31:0];

    assign setup  = psel && !penable;
    assign access = psel && penable;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup) state_d = (WS_INIT != 2'd0) ? WAIT : ISSUE;
            WAIT: begin
                if (!access)              state_d = IDLE;
                else if (wait_q == 2'd1)  state_d = ISSUE;
            end
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= 2'd0;
            wr_q    <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            byte_en <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && setup) begin
                wait_q  <= WS_INIT;
                wr_q    <= pwrite;
                addr    <= paddr;
                wdata   <= pwdata;
                byte_en <= pwrite ? pstrb : 4'h0;
            end else if (state_q == WAIT) begin
                wait_q <= wait_q - 2'd1;
            end
        end
    end

    // Strobes come from latched fields; the live access qualifier only gates an abort in ISSUE.
    assign dec_err  = (addr[1:0] != 2'b00) || (addr > ADDR_LAST);
    assign issue    = (state_q == ISSUE) && access;
    assign r_en     = issue && !wr_q && !dec_err;
    assign w_en     = issue && wr_q && !dec_err && (byte_en != 4'h0);
    assign pready   = issue;
    assign pslverr  = issue && (dec_err || (w_en && error));
    assign tdr1_hit = (addr == ADDR_TDR1) && shadow_valid;
    assign prdata   = r_en ? (tdr1_hit ? hi_shadow : rdata) : 32'h0;

    // Upper counter word frozen by a TDR0 read so the following TDR1 read is coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_shadow    <= '0;
            shadow_valid <= 1'b0;
        end else if (r_en && addr == ADDR_TDR0) begin
            hi_shadow    <= counter[63:32];
            shadow_valid <= 1'b1;
        end else if (r_en && addr == ADDR_TDR1) begin
            shadow_valid <= 1'b0;
        end else if (w_en && (addr == ADDR_TDR0 || addr == ADDR_TDR1)) begin
            shadow_valid <= 1'b0;
        end
    end

endmodule
